// File: rtl/lighting_pkg.sv
// Types and timing constants shared by the lighting blocks
// (button front end and lamp controller).
package lighting_pkg;

    typedef enum logic [2:0] {
        MAN_OFF   = 3'd0,
        MAN_ON    = 3'd1,
        AUTO_IDLE = 3'd2,
        AUTO_ON   = 3'd3,
        AUTO_HOLD = 3'd4
    } lamp_state_t;

    localparam int DEFAULT_OFF_DELAY = 30000;

endpackage

// File: rtl/hold_timer.sv
// Saturating down-counter used as the AUTO switch-off hold timer.
module hold_timer #(
    parameter int                 TIMER_W  = 15,
    parameter logic [TIMER_W-1:0] LOAD_VAL = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [TIMER_W-1:0] count_reg;

    // Load takes precedence over decrement; the count sticks at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= LOAD_VAL;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/lamp_controller.sv
// Lamp controller: AUTO/MANUAL mode FSM driven by press events and a
// synchronized presence sensor, with a programmable switch-off hold.
module lamp_controller
    import lighting_pkg::*;
#(
    parameter int OFF_DELAY = DEFAULT_OFF_DELAY,
    parameter int TIMER_W   = $clog2(OFF_DELAY + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic a_pulse,
    input  logic b_pulse,
    input  logic presence,
    output logic lamp,
    output logic auto_mode,
    output logic hold_active
);

    logic        a_prev_reg;
    logic        b_prev_reg;
    logic        pres_meta_reg;
    logic        pres_s_reg;
    logic        a_ev;
    logic        b_ev;
    logic        timer_load;
    logic        timer_dec;
    logic        timer_zero;
    lamp_state_t state_reg;
    lamp_state_t state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_prev_reg    <= 1'b0;
            b_prev_reg    <= 1'b0;
            pres_meta_reg <= 1'b0;
            pres_s_reg    <= 1'b0;
        end else begin
            a_prev_reg    <= a_pulse;
            b_prev_reg    <= b_pulse;
            pres_meta_reg <= presence;
            pres_s_reg    <= pres_meta_reg;
        end
    end

    // Rising-edge detect so a press held for several cycles counts once.
    assign a_ev = a_pulse & ~a_prev_reg;
    assign b_ev = b_pulse & ~b_prev_reg;

    always_comb begin
        state_next = state_reg;
        timer_load = 1'b0;
        case (state_reg)
            MAN_OFF: begin
                if (a_ev)      state_next = AUTO_IDLE;
                else if (b_ev) state_next = MAN_ON;
            end
            MAN_ON: begin
                if (a_ev) begin
                    state_next = AUTO_HOLD;
                    timer_load = 1'b1;
                end else if (b_ev) begin
                    state_next = MAN_OFF;
                end
            end
            AUTO_IDLE: begin
                if (a_ev)            state_next = MAN_OFF;
                else if (pres_s_reg) state_next = AUTO_ON;
            end
            AUTO_ON: begin
                if (a_ev) begin
                    state_next = MAN_ON;
                end else if (!pres_s_reg) begin
                    state_next = AUTO_HOLD;
                    timer_load = 1'b1;
                end
            end
            AUTO_HOLD: begin
                if (a_ev)            state_next = MAN_ON;
                else if (b_ev)       timer_load = 1'b1;
                else if (pres_s_reg) state_next = AUTO_ON;
                else if (timer_zero) state_next = AUTO_IDLE;
            end
            default: state_next = AUTO_IDLE;
        endcase
    end

    // Counting while in AUTO_HOLD makes the hold last exactly OFF_DELAY cycles.
    assign timer_dec = (state_reg == AUTO_HOLD);

    hold_timer #(
        .TIMER_W  (TIMER_W),
        .LOAD_VAL (TIMER_W'(OFF_DELAY - 1))
    ) u_hold_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .dec  (timer_dec),
        .zero (timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= AUTO_IDLE;
            lamp        <= 1'b0;
            auto_mode   <= 1'b1;
            hold_active <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lamp        <= (state_next == MAN_ON) || (state_next == AUTO_ON) ||
                           (state_next == AUTO_HOLD);
            auto_mode   <= (state_next == AUTO_IDLE) || (state_next == AUTO_ON) ||
                           (state_next == AUTO_HOLD);
            hold_active <= (state_next == AUTO_HOLD);
        end
    end

endmodule
